axis_series_deframer: RTL and testbench
=======================================

// Module: axis_series_deframer
// PURPOSE
//  Receive end of the ADC trigger-series stream. Accepts the valid-only (no tready) 32-bit capture stream.
//  Delimits each series as a contiguous run of s_axis_tvalid=1 and buffers the words in a FIFO.
//  Re-emits each series on a backpressured AXI-Stream toward the DMA, closing it with a trailer word
//  that carries tlast. Sits between the ADC capture core and the DMA writer.
// PARAMETERS
//  FIFO_AW     10   log2 FIFO depth (depth = 2**FIFO_AW entries of 33 bits: data+last)
//  CNT_W       24   width of per-series word counter (saturating)
// PORTS
//  aclk              in   1    system clock, all logic rising-edge
//  aresetn           in   1    reset, synchronous, active-low
//  s_axis_tvalid     in   1    series word valid; no tready, source never stalls
//  s_axis_tdata      in   32   series word
//  m_axis_tvalid     out  1    output word valid
//  m_axis_tready     in   1    downstream accept
//  m_axis_tdata      out  32   output word (series word or trailer)
//  m_axis_tlast      out  1    high on trailer word only
//  series_cnt        out  16   series closed since reset (wraps)
//  drop_cnt          out  16   input words dropped for lack of space (saturates at 16'hFFFF)
//  fifo_level        out  FIFO_AW+1  current occupancy
// BEHAVIOUR
//  Reset (aresetn=0 at a clock edge): FIFO emptied, m_axis_tvalid=0, tdata=0, tlast=0, series_cnt=0,
//   drop_cnt=0, fifo_level=0, seq id=0, in_series=0. Reset mid-series discards the partial series;
//   no trailer is written for it.
//  Input FSM, states IDLE / IN_SERIES:
//   IDLE: tvalid=1 -> store word, word_cnt=1, ovf=0, go IN_SERIES.
//   IN_SERIES: tvalid=1 -> store word, word_cnt+1 (saturates at 2**CNT_W-1); tvalid=0 -> write trailer
//   this cycle, series_cnt+1, seq+1, go IDLE. A new series may start the very next cycle.
//  Store rule: a word is written only if free slots >= 2, so a trailer slot is always reserved.
//   Otherwise the word is dropped, ovf=1, drop_cnt+1, and word_cnt is not incremented.
//   Trailer needs free >= 1, which the reservation guarantees.
//  Trailer word: [31]=ovf, [30]=short (word_cnt<3, i.e. no payload after the two header words),
//   [29:24]=seq id (6b, wraps 63->0), [23:0]=word_cnt of words actually stored. Written with last=1.
//  Output side: show-ahead FIFO with a registered output stage. A word written at edge N is visible
//   with m_axis_tvalid=1 after edge N+1 when the FIFO was empty. A transfer occurs on tvalid&tready.
//   tvalid/tdata/tlast hold stable while tready=0. Sustains 1 word/cycle when tready=1.
//  Simultaneous write and read in one cycle: both occur and fifo_level is unchanged. The full/free
//   computation uses the pre-edge level, so a read in the same cycle does not free a slot for that
//   cycle's write.
//  Pointers are FIFO_AW+1 bits. full = MSBs differ and rest equal; empty = pointers equal; wrap is
//   natural binary.
// STRUCTURE
//  Shared package (adc_stream_pkg): TRL_OVF_BIT=31, TRL_SHORT_BIT=30, TRL_SEQ_MSB/LSB=29/24,
//   TRL_CNT_W=24, SERIES_HDR_WORDS=2, input FSM state enum.
//  Sub-module: axis_sync_fifo (width 33, FIFO_AW, sync reset, show-ahead, level output).
//  Top holds the input FSM, counters and trailer mux.
// TESTING
//  1 Series of 5 words 0x1..0x5, tready=1 -> out 1,2,3,4,5 then trailer 0x00000005 with tlast;
//    series_cnt=1.
//  2 Two series (3 words, idle 1 cycle, 2 words) -> trailers 0x00000003 (seq0) and 0x41000002
//    (short, seq1).
//  3 FIFO_AW=3, tready=0, 10-word series -> 7 words stored; trailer 0x80000007 sits in the 8th slot;
//    drop_cnt=3.
//  4 tready toggled randomly during 100-word series -> output order intact, no dup/loss,
//    data stable while stalled.
//  5 aresetn low for 1 cycle mid-series after 4 words -> all outputs zero next cycle; later
//    3-word series trailer seq=0.
//  6 64 single-word series -> seq wraps 63->0, series_cnt=64, each trailer has short=1 and cnt=1.

Source files
------------

// File: rtl/adc_stream_pkg.sv
// rtl/adc_stream_pkg.sv - shared trailer layout and input FSM state for the ADC series stream
package adc_stream_pkg;

    localparam int TRL_OVF_BIT      = 31;
    localparam int TRL_SHORT_BIT    = 30;
    localparam int TRL_SEQ_MSB      = 29;
    localparam int TRL_SEQ_LSB      = 24;
    localparam int TRL_CNT_W        = 24;
    localparam int SERIES_HDR_WORDS = 2;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_IN_SERIES = 1'b1
    } series_state_t;

    // Assemble the series-closing trailer word from its fields.
    function automatic logic [31:0] make_trailer(
        input logic                 ovf,
        input logic                 short_flag,
        input logic [5:0]           seq_id,
        input logic [TRL_CNT_W-1:0] word_cnt
    );
        logic [31:0] t;
        t                             = '0;
        t[TRL_OVF_BIT]                = ovf;
        t[TRL_SHORT_BIT]              = short_flag;
        t[TRL_SEQ_MSB:TRL_SEQ_LSB]    = seq_id;
        t[TRL_CNT_W-1:0]              = word_cnt;
        return t;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// rtl/axis_sync_fifo.sv - synchronous show-ahead FIFO with registered output stage and level
module axis_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int AW    = 10
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      level
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_ptr_nxt;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push;

    // The word on the output register is still counted as occupying its slot until it is taken.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level      = wr_ptr - rd_ptr;
    assign pop        = rd_valid && rd_ready;
    assign push       = wr_en && !full;
    assign rd_ptr_nxt = rd_ptr + (AW+1)'(1);

    // Storage array, written without reset.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update and output-register refill; a word written this edge shows one edge later.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
                if (rd_ptr_nxt != wr_ptr) begin
                    rd_valid <= 1'b1;
                    rd_data  <= mem[rd_ptr_nxt[AW-1:0]];
                end else begin
                    rd_valid <= 1'b0;
                end
            end else if (!rd_valid && !empty) begin
                rd_valid <= 1'b1;
                rd_data  <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/axis_series_deframer.sv
// rtl/axis_series_deframer.sv - delimits valid-only ADC series, buffers them and appends a trailer
module axis_series_deframer
    import adc_stream_pkg::*;
#(
    parameter int FIFO_AW = 10,
    parameter int CNT_W   = 24
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               s_axis_tvalid,
    input  logic [31:0]        s_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [31:0]        m_axis_tdata,
    output logic               m_axis_tlast,
    output logic [15:0]        series_cnt,
    output logic [15:0]        drop_cnt,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam logic [FIFO_AW:0] DEPTH_W   = (FIFO_AW+1)'(2**FIFO_AW);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] SHORT_LIM = CNT_W'(SERIES_HDR_WORDS + 1);

    series_state_t    state;
    logic [CNT_W-1:0] word_cnt;
    logic             ovf;
    logic [5:0]       seq_id;
    logic [FIFO_AW:0] fifo_free;
    logic             can_store;
    logic             wr_en;
    logic [32:0]      wr_data;
    logic [32:0]      rd_data;
    logic [31:0]      trailer;

    // Free space is judged on the pre-edge level so one slot always stays reserved for the trailer.
    assign fifo_free = DEPTH_W - fifo_level;
    assign can_store = (fifo_free >= (FIFO_AW+1)'(2));
    assign trailer   = make_trailer(ovf, (word_cnt < SHORT_LIM), seq_id, TRL_CNT_W'(word_cnt));

    // Choose what enters the FIFO this cycle: a payload word, the trailer, or nothing.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        if (s_axis_tvalid) begin
            if (can_store) begin
                wr_en   = 1'b1;
                wr_data = {1'b0, s_axis_tdata};
            end
        end else if (state == ST_IN_SERIES) begin
            wr_en   = 1'b1;
            wr_data = {1'b1, trailer};
        end
    end

    // Input FSM: track the open series, its stored-word count, overflow flag and counters.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            word_cnt   <= '0;
            ovf        <= 1'b0;
            seq_id     <= '0;
            series_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            if (s_axis_tvalid && !can_store && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (s_axis_tvalid) begin
                        state    <= ST_IN_SERIES;
                        ovf      <= !can_store;
                        word_cnt <= can_store ? CNT_W'(1) : '0;
                    end
                end
                ST_IN_SERIES: begin
                    if (s_axis_tvalid) begin
                        if (!can_store) begin
                            ovf <= 1'b1;
                        end else if (word_cnt != CNT_MAX) begin
                            word_cnt <= word_cnt + CNT_W'(1);
                        end
                    end else begin
                        state      <= ST_IDLE;
                        series_cnt <= series_cnt + 16'd1;
                        seq_id     <= seq_id + 6'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    axis_sync_fifo #(
        .WIDTH (33),
        .AW    (FIFO_AW)
    ) u_fifo (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_valid (m_axis_tvalid),
        .rd_ready (m_axis_tready),
        .rd_data  (rd_data),
        .level    (fifo_level)
    );

    assign m_axis_tlast = rd_data[32];
    assign m_axis_tdata = rd_data[31:0];

endmodule

// File: tb/tb_axis_series_deframer.sv
// tb/tb_axis_series_deframer.sv - self-checking bench for axis_series_deframer
module tb_axis_series_deframer;

    localparam int AW_B = 10;
    localparam int AW_S = 3;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        s_tvalid = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        m_tready = 1'b0;

    logic        b_tvalid, b_tlast;
    logic [31:0] b_tdata;
    logic [15:0] b_scnt, b_dcnt;
    logic [AW_B:0] b_lvl;
    logic        s_otvalid, s_tlast;
    logic [31:0] s_otdata;
    logic [15:0] s_scnt, s_dcnt;
    logic [AW_S:0] s_lvl;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 0;

    // Behavioural model state, index 0 = large FIFO, index 1 = 8-entry FIFO
    int          m_inser[2], m_wcnt[2], m_ovf[2], m_seq[2], m_scnt[2], m_dcnt[2];
    int          m_ov[2], m_mh[2], m_mc[2];
    logic [32:0] m_od[2];
    logic [32:0] m_mem[2][1024];

    logic [32:0] cap0[512];
    logic [32:0] cap1[512];
    int          n0 = 0, n1 = 0;
    logic [31:0] sent[100];

    always #5 aclk = ~aclk;

    axis_series_deframer #(.FIFO_AW(AW_B), .CNT_W(24)) dut_big (
        .aclk(aclk), .aresetn(aresetn), .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata),
        .m_axis_tvalid(b_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(b_tdata),
        .m_axis_tlast(b_tlast), .series_cnt(b_scnt), .drop_cnt(b_dcnt), .fifo_level(b_lvl));

    axis_series_deframer #(.FIFO_AW(AW_S), .CNT_W(24)) dut_small (
        .aclk(aclk), .aresetn(aresetn), .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata),
        .m_axis_tvalid(s_otvalid), .m_axis_tready(m_tready), .m_axis_tdata(s_otdata),
        .m_axis_tlast(s_tlast), .series_cnt(s_scnt), .drop_cnt(s_dcnt), .fifo_level(s_lvl));

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // One clock of the model: queue of buffered words plus the word currently presented
    task automatic model_step(input int k, input int depth);
        int          lvl;
        bit          we;
        bit          tr;
        logic [32:0] wd;
        if (!aresetn) begin
            m_inser[k] = 0; m_wcnt[k] = 0; m_ovf[k] = 0; m_seq[k] = 0;
            m_scnt[k] = 0; m_dcnt[k] = 0; m_ov[k] = 0; m_mh[k] = 0; m_mc[k] = 0;
            m_od[k] = '0;
            return;
        end
        tr  = (m_ov[k] != 0) && m_tready;
        lvl = m_mc[k] + m_ov[k];
        we  = 0;
        wd  = '0;
        if (s_tvalid) begin
            if (m_inser[k] == 0) begin
                m_wcnt[k] = 0; m_ovf[k] = 0; m_inser[k] = 1;
            end
            if (depth - lvl >= 2) begin
                we = 1;
                wd = {1'b0, s_tdata};
                if (m_wcnt[k] < 24'hFFFFFF) m_wcnt[k]++;
            end else begin
                m_ovf[k] = 1;
                if (m_dcnt[k] < 65535) m_dcnt[k]++;
            end
        end else if (m_inser[k] != 0) begin
            we = 1;
            wd = {1'b1, 32'(m_ovf[k]) * 32'h80000000
                      + ((m_wcnt[k] < 3) ? 32'h40000000 : 32'h0)
                      + 32'(m_seq[k]) * 32'h01000000
                      + 32'(m_wcnt[k])};
            m_scnt[k] = (m_scnt[k] + 1) % 65536;
            m_seq[k]  = (m_seq[k] + 1) % 64;
            m_inser[k] = 0;
        end
        if (tr || m_ov[k] == 0) begin
            if (m_mc[k] > 0) begin
                m_ov[k] = 1;
                m_od[k] = m_mem[k][m_mh[k]];
                m_mh[k] = (m_mh[k] + 1) % 1024;
                m_mc[k]--;
            end else begin
                m_ov[k] = 0;
            end
        end
        if (we) begin
            m_mem[k][(m_mh[k] + m_mc[k]) % 1024] = wd;
            m_mc[k]++;
        end
    endtask

    always @(posedge aclk) begin
        model_step(0, 1 << AW_B);
        model_step(1, 1 << AW_S);
    end

    // Compare both DUTs against the model each cycle, and log accepted output words
    always @(negedge aclk) begin
        if (started) begin
            check("dut_big_outputs",
                  {b_tvalid, b_tlast, b_tdata, b_scnt, b_dcnt, 14'(b_lvl)},
                  {1'(m_ov[0]), m_od[0][32], m_od[0][31:0], 16'(m_scnt[0]), 16'(m_dcnt[0]),
                   14'(m_mc[0] + m_ov[0])});
            check("dut_small_outputs",
                  {s_otvalid, s_tlast, s_otdata, s_scnt, s_dcnt, 14'(s_lvl)},
                  {1'(m_ov[1]), m_od[1][32], m_od[1][31:0], 16'(m_scnt[1]), 16'(m_dcnt[1]),
                   14'(m_mc[1] + m_ov[1])});
        end
        if (b_tvalid && m_tready && n0 < 512) begin cap0[n0] = {b_tlast, b_tdata}; n0++; end
        if (s_otvalid && m_tready && n1 < 512) begin cap1[n1] = {s_tlast, s_otdata}; n1++; end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset(input int n);
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        repeat (n) tick();
        aresetn = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] d);
        s_tvalid = 1'b1;
        s_tdata  = d;
        tick();
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        do_reset(3);
        started = 1;
        check("reset_tvalid", 64'(b_tvalid), 64'd0);
        check("reset_level", 64'(b_lvl), 64'd0);

        // Test 1: five-word series
        m_tready = 1'b1;
        n0 = 0;
        for (int i = 1; i <= 5; i++) send_word(32'(i));
        idle(10);
        check("t1_count", 64'(n0), 64'd6);
        for (int i = 0; i < 5; i++) check("t1_word", 64'(cap0[i]), 64'(i + 1));
        check("t1_trailer", 64'(cap0[5]), 64'h1_0000_0005);
        check("t1_series_cnt", 64'(b_scnt), 64'd1);

        // Test 2: 3-word and 2-word series with one idle cycle between
        do_reset(2);
        n0 = 0;
        send_word(32'h11); send_word(32'h12); send_word(32'h13);
        idle(1);
        send_word(32'h21); send_word(32'h22);
        idle(10);
        check("t2_count", 64'(n0), 64'd7);
        check("t2_trailer0", 64'(cap0[3]), 64'h1_0000_0003);
        check("t2_trailer1", 64'(cap0[6]), 64'h1_4100_0002);

        // Test 3: 10 words into the 8-entry FIFO with no reads
        do_reset(2);
        m_tready = 1'b0;
        for (int i = 1; i <= 10; i++) send_word(32'(i));
        idle(3);
        check("t3_level", 64'(s_lvl), 64'd8);
        check("t3_drop_cnt", 64'(s_dcnt), 64'd3);
        check("t3_model_drop", 64'(m_dcnt[1]), 64'd3);
        n1 = 0;
        n0 = 0;
        m_tready = 1'b1;
        idle(15);
        check("t3_count", 64'(n1), 64'd8);
        for (int i = 0; i < 7; i++) check("t3_word", 64'(cap1[i]), 64'(i + 1));
        check("t3_trailer", 64'(cap1[7]), 64'h1_8000_0007);
        check("t3_big_trailer", 64'(cap0[10]), 64'h1_0000_000A);

        // Test 4: 100-word series with random backpressure
        n0 = 0;
        for (int i = 0; i < 100; i++) begin
            sent[i]  = $urandom;
            m_tready = 1'($urandom_range(0, 1));
            send_word(sent[i]);
        end
        s_tvalid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            m_tready = 1'($urandom_range(0, 1));
            tick();
        end
        m_tready = 1'b1;
        idle(20);
        check("t4_count", 64'(n0), 64'd101);
        for (int i = 0; i < 100; i++) begin
            if (cap0[i] !== {1'b0, sent[i]}) check("t4_order", 64'(cap0[i]), 64'({1'b0, sent[i]}));
        end
        check("t4_trailer", 64'(cap0[100]), 64'h1_0100_0064);

        // Test 5: reset in the middle of a series
        n0 = 0;
        for (int i = 1; i <= 4; i++) send_word(32'hA0 + 32'(i));
        aresetn  = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 32'hA5;
        tick();
        aresetn  = 1'b1;
        s_tvalid = 1'b0;
        check("t5_rst_outputs", {b_tvalid, b_tlast, b_tdata, b_scnt, b_dcnt}, 64'd0);
        check("t5_rst_level", 64'(b_lvl), 64'd0);
        idle(2);
        n0 = 0;
        send_word(32'hB1); send_word(32'hB2); send_word(32'hB3);
        idle(10);
        check("t5_count", 64'(n0), 64'd4);
        check("t5_trailer", 64'(cap0[3]), 64'h1_0000_0003);

        // Test 6: 65 single-word series, sequence id wraps
        do_reset(2);
        n0 = 0;
        for (int i = 0; i < 65; i++) begin
            if (i == 64) check("t6_series_cnt64", 64'(b_scnt), 64'd64);
            send_word(32'h1000 + 32'(i));
            idle(1);
        end
        idle(10);
        check("t6_count", 64'(n0), 64'd130);
        for (int i = 0; i < 65; i++) begin
            if (cap0[2*i+1] !== {1'b1, 32'h40000001 + 32'(i % 64) * 32'h01000000})
                check("t6_trailer", 64'(cap0[2*i+1]),
                      64'({1'b1, 32'h40000001 + 32'(i % 64) * 32'h01000000}));
        end
        check("t6_trailer_wrap", 64'(cap0[129]), 64'h1_4000_0001);
        check("t6_series_cnt", 64'(b_scnt), 64'd65);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
